hazard_ctrl_pipe: RTL
=====================

# hazard_ctrl_pipe

Consumer end of the main control decoder: takes the per-instruction control bits from the ID stage and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers alongside destination register numbers. Detects data hazards and stalls the front end, kills wrong-path instructions on taken branches and jumps, and, when configured, drives the datapath forwarding muxes. Sits between the control decoder and the five-stage MIPS datapath.

## Interface
- No parameters; widths fixed (5-bit register numbers, 2-bit ALUOp, 16-bit counter).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump  in  1 each  decoder outputs for the instruction in ID
- id_ALUOp  in  2  decoder ALUOp
- id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID
- mem_zero  in  1  ALU zero flag held in EX/MEM by the datapath
- ex_RegDst, ex_ALUSrc  out  1  EX-stage controls; ex_ALUOp out 2
- ex_rs, ex_rt  out  5  EX-stage source register numbers
- mem_MemRead, mem_MemWrite, mem_Branch  out  1  MEM-stage controls
- wb_RegWrite, wb_MemtoReg  out  1  WB-stage controls; wb_wreg out 5 register-file write address
- pc_write, ifid_write  out  1  enables for PC and IF/ID registers
- pc_src_branch, pc_src_jump, if_flush  out  1  PC select and IF/ID kill
- forward_a, forward_b  out  2  ALU operand A/B source select
- bubble_count  out  16  saturating count of injected bubbles

## Operation
- Stage registers: ID/EX holds all id_* controls plus rs, rt, rd; EX computes ex_wreg = ex_RegDst ? ex_rd : ex_rt; EX/MEM holds MemRead, MemWrite, Branch, RegWrite, MemtoReg, wreg; MEM/WB holds RegWrite, MemtoReg, wreg.
- Register 0 never matches in any hazard or forward comparison; id_rt compared regardless of opcode (conservative).
- branch_taken = mem_Branch & mem_zero. Drives pc_src_branch and if_flush; on next edge ID/EX and EX/MEM controls cleared to 0 (register numbers don't care).
- stall (see Configuration) forces pc_write=0, ifid_write=0, loads all-zero controls into ID/EX (bubble), increments bubble_count (saturates at 16'hFFFF).
- pc_src_jump = id_Jump & ~stall; if_flush = branch_taken | pc_src_jump.
- Priority: branch_taken > stall > jump. When branch_taken, stall is suppressed (pc_write=1, ifid_write=1), no bubble counted.
- WB→ID: register file writes first half-cycle; no hazard tracked for WB stage.

## Timing
- All stage registers and bubble_count update on rising clk; stall, flush, pc_* and forward_* are combinational from current stage registers and id_* inputs, same cycle.
- Control latency: id_* appears on ex_* 1 cycle later, mem_* 2, wb_* 3.
- Reset (async, immediate): all stage controls 0, all register numbers 0, bubble_count 0; hence pc_write=1, ifid_write=1, pc_src_*=0, if_flush=0, forward_*=00.
- Reset mid-operation discards all in-flight controls; no partial writes after rst_n rises.
- Load-use stall lasts exactly 1 cycle; non-forwarding RAW stall lasts up to 2 cycles.

## Configuration
- HAZARD_FORWARD_EN defined: forward_unit instantiated. forward_a = 10 if mem RegWrite & mem wreg==ex_rs, else 01 if wb_RegWrite & wb_wreg==ex_rs, else 00; forward_b same with ex_rt; EX/MEM wins ties. stall only on load-use: ex_MemRead & (ex_rt==id_rs | ex_rt==id_rt).
- Undefined: forward_a/forward_b tied 00. stall when id_rs or id_rt matches ex_wreg (ex_RegWrite) or EX/MEM wreg (mem RegWrite).

## Structure
- Shared package ctrl_pipe_pkg: opcode constants (R_FORMAT 0, J 2, BEQ 4, LW 35, SW 43), ALUOp encodings (00 add, 01 sub, 10 funct), forward select encodings (00 reg, 01 MEM/WB, 10 EX/MEM), control-bundle typedef.
- One sub-module: forward_unit (combinational comparators), present only under HAZARD_FORWARD_EN.

## Test plan
- Reset: assert rst_n=0 mid-stream with ex_RegWrite=1 -> all controls 0, pc_write=1, bubble_count=0 immediately.
- R-format (RegDst=1, RegWrite=1, ALUOp=10, rd=8) -> ex_ALUOp=10 at +1, wb_RegWrite=1, wb_wreg=8 at +3.
- LW $9 then add using $9 -> one cycle pc_write=0, ifid_write=0, bubble in ID/EX, bubble_count=1; with FORWARD_EN next cycle forward_a=01.
- Back-to-back R-format writing $10 then reading $10 -> with FORWARD_EN forward_a=10, no stall; without, 2 stall cycles, bubble_count=2.
- BEQ with mem_zero=1 while younger LW-use stall pending -> pc_src_branch=1, if_flush=1, pc_write=1, ID/EX and EX/MEM controls 0 next cycle, bubble_count unchanged.
- J in ID (id_Jump=1, no hazard) -> pc_src_jump=1, if_flush=1 same cycle; with coincident stall -> pc_src_jump=0 until stall clears.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline: opcode constants, ALUOp and
// forward-select encodings, the control bundle carried into EX, and the
// register-number compare used by all hazard/forward checks.
package ctrl_pipe_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FWD_W   = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_R_FORMAT = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J        = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ      = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LW       = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW       = OP_W'(43);

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [FWD_W-1:0] FWD_REG   = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

  // Controls latched into ID/EX; Jump resolves in ID and is not carried.
  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic                memto_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic [ALUOP_W-1:0]  alu_op;
  } ctrl_t;

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_pipe_forward_unit.sv
// forward_unit: selects ALU operand sources from EX/MEM and MEM/WB results.
// Ports: ex_rs/ex_rt (EX sources), mem_reg_write/mem_wreg (EX/MEM dest),
//        wb_reg_write/wb_wreg (MEM/WB dest), forward_a_c/forward_b_c (selects).
module forward_unit
  import ctrl_pipe_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_wreg,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_wreg,
  output logic [FWD_W-1:0] forward_a_c,
  output logic [FWD_W-1:0] forward_b_c
);

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  function automatic logic [FWD_W-1:0] sel(input logic [REG_W-1:0] src);
    if (mem_reg_write && reg_match(mem_wreg, src)) return FWD_EXMEM;
    if (wb_reg_write && reg_match(wb_wreg, src))   return FWD_MEMWB;
    return FWD_REG;
  endfunction

  always_comb begin
    forward_a_c = sel(ex_rs);
    forward_b_c = sel(ex_rt);
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: carries decoder controls through ID/EX, EX/MEM, MEM/WB,
// detects data hazards (stall + bubble), kills wrong-path work on taken
// branches/jumps, and optionally drives the forwarding muxes.
// Build option: define HAZARD_FORWARD_EN to instantiate forward_unit and
// stall only on load-use; otherwise forwarding is tied off and any RAW
// dependency on EX or MEM stalls.
// Ports: id_* decoder controls/fields in, mem_zero in; ex_*/mem_*/wb_* stage
// controls out; pc_write/ifid_write/pc_src_*/if_flush front-end control out;
// forward_a/b operand selects out; bubble_count saturating bubble counter.
module hazard_ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_MemtoReg,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_Branch,
  input  logic               id_Jump,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               mem_zero,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_Branch,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [REG_W-1:0]   wb_wreg,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               pc_src_branch,
  output logic               pc_src_jump,
  output logic               if_flush,
  output logic [FWD_W-1:0]   forward_a,
  output logic [FWD_W-1:0]   forward_b,
  output logic [CNT_W-1:0]   bubble_count
);

  ctrl_t            id_ctrl;
  ctrl_t            ex_ctrl;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] ex_wreg;
  logic             mem_reg_write;
  logic             mem_memto_reg;
  logic [REG_W-1:0] mem_wreg;
  logic             stall_raw;
  logic             stall;
  logic             branch_taken;

  assign id_ctrl = '{reg_dst:   id_RegDst,   alu_src:   id_ALUSrc,
                     memto_reg: id_MemtoReg, reg_write: id_RegWrite,
                     mem_read:  id_MemRead,  mem_write: id_MemWrite,
                     branch:    id_Branch,   alu_op:    id_ALUOp};

  assign ex_RegDst = ex_ctrl.reg_dst;
  assign ex_ALUSrc = ex_ctrl.alu_src;
  assign ex_ALUOp  = ex_ctrl.alu_op;
  assign ex_wreg   = ex_ctrl.reg_dst ? ex_rd : ex_rt;

`ifdef HAZARD_FORWARD_EN
  forward_unit u_forward_unit (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_reg_write (mem_reg_write),
    .mem_wreg      (mem_wreg),
    .wb_reg_write  (wb_RegWrite),
    .wb_wreg       (wb_wreg),
    .forward_a_c   (forward_a),
    .forward_b_c   (forward_b)
  );
`else
  assign forward_a = FWD_REG;
  assign forward_b = FWD_REG;
`endif

  // Hazard detection and front-end control; a taken branch overrides stall.
  always_comb begin
    stall_raw = 1'b0;
`ifdef HAZARD_FORWARD_EN
    stall_raw = ex_ctrl.mem_read &
                (reg_match(ex_rt, id_rs) | reg_match(ex_rt, id_rt));
`else
    stall_raw = (ex_ctrl.reg_write &
                 (reg_match(ex_wreg, id_rs) | reg_match(ex_wreg, id_rt))) |
                (mem_reg_write &
                 (reg_match(mem_wreg, id_rs) | reg_match(mem_wreg, id_rt)));
`endif
    branch_taken  = mem_Branch & mem_zero;
    stall         = stall_raw & ~branch_taken;
    pc_write      = ~stall;
    ifid_write    = ~stall;
    pc_src_branch = branch_taken;
    pc_src_jump   = id_Jump & ~stall;
    if_flush      = branch_taken | pc_src_jump;
  end

  // Stage registers and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl       <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      mem_MemRead   <= 1'b0;
      mem_MemWrite  <= 1'b0;
      mem_Branch    <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_memto_reg <= 1'b0;
      mem_wreg      <= '0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_wreg       <= '0;
      bubble_count  <= '0;
    end else begin
      ex_ctrl <= (branch_taken || stall) ? '0 : id_ctrl;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_rd   <= id_rd;

      if (branch_taken) begin
        mem_MemRead   <= 1'b0;
        mem_MemWrite  <= 1'b0;
        mem_Branch    <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_memto_reg <= 1'b0;
      end else begin
        mem_MemRead   <= ex_ctrl.mem_read;
        mem_MemWrite  <= ex_ctrl.mem_write;
        mem_Branch    <= ex_ctrl.branch;
        mem_reg_write <= ex_ctrl.reg_write;
        mem_memto_reg <= ex_ctrl.memto_reg;
      end
      mem_wreg <= ex_wreg;

      wb_RegWrite <= mem_reg_write;
      wb_MemtoReg <= mem_memto_reg;
      wb_wreg     <= mem_wreg;

      if (stall && (bubble_count != {CNT_W{1'b1}}))
        bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
